// File: rtl/vram_arbiter.sv
// Video RAM arbiter: shares one asynchronous SRAM between CPU byte accesses
// and VPU DMA burst reads, using the DMA engine's hold/vramcs/vrambusy handshake.
module vram_arbiter #(
    parameter int MEM_WAIT = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_addr,
    input  logic [7:0]  cpu_di,
    output logic [7:0]  cpu_do,
    input  logic        cpu_rw,
    input  logic        cpu_cs,
    output logic        cpu_ready,
    input  logic [15:0] dma_addr,
    output logic [7:0]  dma_data,
    input  logic        dma_cs,
    input  logic        dma_hold,
    output logic        dma_busy,
    output logic [15:0] mem_addr,
    input  logic [7:0]  mem_di,
    output logic [7:0]  mem_do,
    output logic        mem_we,
    output logic        mem_oe
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CPU_RD = 2'd1,
        CPU_WR = 2'd2,
        GRANT  = 2'd3
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t      state;
    logic [3:0]  wcnt;
    logic [15:0] cpu_addr_r;
    logic        mem_we_r;
    logic        mem_oe_r;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= 4'd0;
            cpu_do     <= 8'd0;
            cpu_addr_r <= 16'd0;
            mem_do     <= 8'd0;
            cpu_ready  <= 1'b0;
            mem_we_r   <= 1'b0;
            mem_oe_r   <= 1'b0;
        end else begin
            cpu_ready <= 1'b0;
            case (state)
                IDLE: begin
                    // A hold already raised beats a CPU request arriving in the same cycle.
                    if (dma_hold) begin
                        state <= GRANT;
                    end else if (cpu_cs) begin
                        cpu_addr_r <= cpu_addr;
                        wcnt       <= WAIT_INIT;
                        if (cpu_rw) begin
                            state    <= CPU_RD;
                            mem_oe_r <= 1'b1;
                        end else begin
                            state    <= CPU_WR;
                            mem_do   <= cpu_di;
                            mem_we_r <= 1'b1;
                        end
                    end
                end
                CPU_RD, CPU_WR: begin
                    if (wcnt != 4'd0) begin
                        wcnt <= wcnt - 4'd1;
                    end else begin
                        if (state == CPU_RD) begin
                            cpu_do <= mem_di;
                        end
                        mem_we_r  <= 1'b0;
                        mem_oe_r  <= 1'b0;
                        cpu_ready <= 1'b1;
                        state     <= IDLE;
                    end
                end
                GRANT: begin
                    if (!dma_hold) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // During a grant the DMA engine drives the SRAM directly with zero-latency reads.
    assign mem_addr = (state == GRANT) ? dma_addr : cpu_addr_r;
    assign mem_oe   = (state == GRANT) ? dma_cs   : mem_oe_r;
    assign mem_we   = (state == GRANT) ? 1'b0     : mem_we_r;
    assign dma_data = mem_di;

    assign dma_busy = rst | (state == CPU_RD) | (state == CPU_WR)
                    | ((state == IDLE) & cpu_cs);

endmodule
